// File: rtl/wbi2c_pkg.sv
// Shared definitions for the WBI2C family: FSM encodings, register map
// offsets, CTRL bit positions and byte-lane helpers for the 32-bit memory.
package wbi2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK,
        S_RXPTR,
        S_RXDATA,
        S_TXDATA,
        S_TXACK,
        S_IGNORE
    } state_t;

    // Register-space word offsets (selected by wishbone address bit 0)
    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_PTR  = 1'b1;

    // CTRL bit positions
    localparam int CTRL_ADDR_LSB  = 0;
    localparam int CTRL_ADDR_W    = 7;
    localparam int CTRL_LOCK_BIT  = 8;
    localparam int CTRL_WROTE_BIT = 30;
    localparam int CTRL_BUSY_BIT  = 31;

    // Byte lane 0 is the most significant byte of a memory word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/i2c_busdet.sv
// I2C bus condition detector: two-flop synchronisers plus a history flop on
// SCL and SDA, decoding START, STOP and SCL rising/falling edge pulses.
module i2c_busdet (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_rise,
    output logic o_fall
);

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;

    // Synchronise the raw bus levels and keep one cycle of history for edges
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
        end
    end

    assign o_sda   = r_sda_sync;
    assign o_rise  = r_scl_sync & ~r_scl_hist;
    assign o_fall  = ~r_scl_sync & r_scl_hist;
    // SDA transitions are only bus conditions while SCL is stable high
    assign o_start = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
    assign o_stop  = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;

endmodule

// File: rtl/wbi2cslave.sv
// I2C target with a 128-byte memory shared with a local Wishbone master.
// EEPROM-style protocol: address+W, pointer, data...; address+R streams out.
module wbi2cslave
    import wbi2c_pkg::*;
#(
    parameter int         MEM_ADDR_BITS = 7,
    parameter logic [6:0] SLAVE_ADDR    = 7'h50,
    parameter logic       READ_ONLY     = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [MEM_ADDR_BITS-2:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [31:0]              o_wb_data,
    input  logic                     i_i2c_scl,
    input  logic                     i_i2c_sda,
    output logic                     o_i2c_scl,
    output logic                     o_i2c_sda,
    output logic                     o_int
);

    localparam int WORD_BITS = MEM_ADDR_BITS - 2;
    localparam int WORDS     = 1 << WORD_BITS;
    localparam logic [MEM_ADDR_BITS-1:0] PTR_ONE = {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};

    // Bus condition pulses
    logic w_sda, w_start, w_stop, w_rise, w_fall;

    // FSM state and next-state values
    state_t                   r_state, w_state_nx;
    state_t                   r_after, w_after_nx;
    logic [3:0]               r_bitcnt, w_bitcnt_nx;
    logic [7:0]               r_shift, w_shift_nx;
    logic                     r_sda, w_sda_nx;
    logic [MEM_ADDR_BITS-1:0] r_ptr, w_ptr_nx;
    logic                     r_busy, w_busy_nx;
    logic                     w_pend_set, w_stop_evt, w_int_fire;

    // Completed I2C byte awaiting a free memory write slot
    logic                     r_pend_vld;
    logic [MEM_ADDR_BITS-1:0] r_pend_addr;
    logic [7:0]               r_pend_data;
    logic                     r_txn_wrote, r_int;

    // Wishbone side
    logic                 r_ack;
    logic [31:0]          r_rdata;
    logic                 r_wbw_vld;
    logic [WORD_BITS-1:0] r_wbw_word;
    logic [31:0]          r_wbw_data;
    logic [3:0]           r_wbw_sel;
    logic [6:0]           r_addr;
    logic                 r_lock, r_wrote;
    logic                 w_wb_mem;
    logic [WORD_BITS-1:0] w_wb_word;
    logic [7:0]           w_tx_byte;
    logic                 w_unused;

    logic [31:0] r_mem [WORDS];

    i2c_busdet u_busdet (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_scl   (i_i2c_scl),
        .i_sda   (i_i2c_sda),
        .o_sda   (w_sda),
        .o_start (w_start),
        .o_stop  (w_stop),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_wb_mem   = i_wb_addr[MEM_ADDR_BITS-2];
    assign w_wb_word  = i_wb_addr[WORD_BITS-1:0];
    assign w_tx_byte  = lane_byte(r_mem[r_ptr[MEM_ADDR_BITS-1:2]], r_ptr[1:0]);
    assign w_int_fire = w_stop_evt & r_txn_wrote;
    assign w_unused   = i_wb_cyc;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    // Next-state and datapath decisions, driven by bus pulses
    always_comb begin
        w_state_nx  = r_state;
        w_after_nx  = r_after;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_sda_nx    = r_sda;
        w_ptr_nx    = r_ptr;
        w_busy_nx   = r_busy;
        w_pend_set  = 1'b0;
        w_stop_evt  = 1'b0;
        if (w_start) begin
            w_state_nx  = S_ADDR;
            w_bitcnt_nx = 4'd0;
            w_sda_nx    = 1'b1;
        end else if (w_stop) begin
            w_state_nx = S_IDLE;
            w_sda_nx   = 1'b1;
            w_busy_nx  = 1'b0;
            w_stop_evt = 1'b1;
        end else begin
            case (r_state)
                S_ADDR, S_RXPTR, S_RXDATA: begin
                    if (w_rise && r_bitcnt < 4'd8) begin
                        w_shift_nx  = {r_shift[6:0], w_sda};
                        w_bitcnt_nx = r_bitcnt + 4'd1;
                    end else if (w_fall && r_bitcnt == 4'd8) begin
                        w_bitcnt_nx = 4'd0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == r_addr) begin
                                w_busy_nx  = 1'b1;
                                w_sda_nx   = 1'b0;
                                w_state_nx = S_ACK;
                                w_after_nx = r_shift[0] ? S_TXDATA : S_RXPTR;
                            end else begin
                                w_state_nx = S_IGNORE;
                            end
                        end else if (r_state == S_RXPTR) begin
                            w_ptr_nx   = r_shift[MEM_ADDR_BITS-1:0];
                            w_sda_nx   = 1'b0;
                            w_state_nx = S_ACK;
                            w_after_nx = S_RXDATA;
                        end else begin
                            // A refused data byte still takes its ACK slot, SDA released
                            w_state_nx = S_ACK;
                            w_after_nx = S_RXDATA;
                            if (!READ_ONLY && !r_lock) begin
                                w_pend_set = 1'b1;
                                w_ptr_nx   = r_ptr + PTR_ONE;
                                w_sda_nx   = 1'b0;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_rise && r_after == S_TXDATA) begin
                        w_shift_nx = w_tx_byte;
                    end else if (w_fall) begin
                        w_state_nx  = r_after;
                        w_bitcnt_nx = 4'd0;
                        w_sda_nx    = 1'b1;
                        if (r_after == S_TXDATA) begin
                            w_sda_nx    = r_shift[7];
                            w_shift_nx  = {r_shift[6:0], 1'b0};
                            w_bitcnt_nx = 4'd1;
                        end
                    end
                end
                S_TXDATA: begin
                    if (w_fall) begin
                        if (r_bitcnt < 4'd8) begin
                            w_sda_nx    = r_shift[7];
                            w_shift_nx  = {r_shift[6:0], 1'b0};
                            w_bitcnt_nx = r_bitcnt + 4'd1;
                        end else begin
                            w_sda_nx   = 1'b1;
                            w_state_nx = S_TXACK;
                            w_ptr_nx   = r_ptr + PTR_ONE;
                        end
                    end
                end
                S_TXACK: begin
                    if (w_rise) begin
                        if (w_sda) w_state_nx = S_IGNORE;
                        else       w_shift_nx = w_tx_byte;
                    end else if (w_fall) begin
                        w_state_nx  = S_TXDATA;
                        w_sda_nx    = r_shift[7];
                        w_shift_nx  = {r_shift[6:0], 1'b0};
                        w_bitcnt_nx = 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM-owned datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_after  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'd0;
            r_sda    <= 1'b1;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_after  <= w_after_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shift  <= w_shift_nx;
            r_sda    <= w_sda_nx;
            r_ptr    <= w_ptr_nx;
            r_busy   <= w_busy_nx;
        end
    end

    // Pending I2C byte, transaction write tracking and interrupt pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= 8'd0;
            r_txn_wrote <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            r_int <= w_int_fire;
            if (w_pend_set) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= r_ptr;
                r_pend_data <= r_shift;
                r_txn_wrote <= 1'b1;
            end else if (r_pend_vld && !r_wbw_vld) begin
                r_pend_vld <= 1'b0;
            end
            if (w_stop_evt) r_txn_wrote <= 1'b0;
        end
    end

    // Wishbone ack, read data, registered memory write port and CTRL fields
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack      <= 1'b0;
            r_rdata    <= 32'd0;
            r_wbw_vld  <= 1'b0;
            r_wbw_word <= '0;
            r_wbw_data <= 32'd0;
            r_wbw_sel  <= 4'd0;
            r_addr     <= SLAVE_ADDR;
            r_lock     <= 1'b0;
            r_wrote    <= 1'b0;
        end else begin
            r_ack      <= i_wb_stb;
            r_wbw_vld  <= i_wb_stb & i_wb_we & w_wb_mem;
            r_wbw_word <= w_wb_word;
            r_wbw_data <= i_wb_data;
            r_wbw_sel  <= i_wb_sel;
            if (i_wb_stb && i_wb_we && !w_wb_mem && i_wb_addr[0] == REG_CTRL) begin
                if (i_wb_sel[0]) r_addr <= i_wb_data[CTRL_ADDR_LSB +: CTRL_ADDR_W];
                if (i_wb_sel[1]) r_lock <= i_wb_data[CTRL_LOCK_BIT];
                r_wrote <= 1'b0;
            end
            // A transaction ending in the same cycle keeps the flag set
            if (w_int_fire) r_wrote <= 1'b1;
            if (i_wb_stb && !i_wb_we) begin
                if (w_wb_mem)
                    r_rdata <= r_mem[w_wb_word];
                else if (i_wb_addr[0] == REG_CTRL)
                    r_rdata <= {r_busy, r_wrote, 21'd0, r_lock, 1'b0, r_addr};
                else
                    r_rdata <= {{(32-MEM_ADDR_BITS){1'b0}}, r_ptr};
            end
        end
    end

    // Shared memory: Wishbone writes take priority, a pending I2C byte fills the gap
    always_ff @(posedge i_clk) begin
        if (r_wbw_vld) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wbw_sel[i]) r_mem[r_wbw_word][i*8 +: 8] <= r_wbw_data[i*8 +: 8];
            end
        end else if (r_pend_vld) begin
            r_mem[r_pend_addr[MEM_ADDR_BITS-1:2]] <=
                lane_merge(r_mem[r_pend_addr[MEM_ADDR_BITS-1:2]], r_pend_addr[1:0], r_pend_data);
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;
    assign o_i2c_scl  = 1'b1;
    assign o_i2c_sda  = r_sda;
    assign o_int      = r_int;

endmodule

// File: tb/tb_wbi2cslave.sv
// Self-checking bench for wbi2cslave: bit-banged I2C master on a wired-AND
// bus, Wishbone master tasks, scoreboard queue of expected results.
module tb_wbi2cslave;

    localparam int Q = 20;  // clocks per quarter SCL period

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [5:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic        m_scl = 1'b1, m_sda = 1'b1;
    logic        s_scl, s_sda, dut_int;
    logic        bus_scl, bus_sda;

    int n_checks = 0;
    int n_errors = 0;
    int int_cnt = 0;
    int sda_low_cnt = 0;
    logic [31:0] exp_q[$];

    assign bus_scl = m_scl & s_scl;
    assign bus_sda = m_sda & s_sda;

    always #5 clk = ~clk;

    wbi2cslave dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_wdata),
        .i_wb_sel   (wb_sel),
        .o_wb_ack   (wb_ack),
        .o_wb_stall (wb_stall),
        .o_wb_data  (wb_rdata),
        .i_i2c_scl  (bus_scl),
        .i_i2c_sda  (bus_sda),
        .o_i2c_scl  (s_scl),
        .o_i2c_sda  (s_sda),
        .o_int      (dut_int)
    );

    always @(posedge clk) begin
        if (dut_int === 1'b1) int_cnt++;
        if (s_sda === 1'b0) sda_low_cnt++;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
        chk(tag, got, e);
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = a; wb_wdata = d; wb_sel = s;
        @(negedge clk);
        chk("wb_wr_ack", {31'd0, wb_ack}, 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(negedge clk);
        sb_check(tag, wb_rdata);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b1; wait_q(Q);
        wait_q(10);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q(Q);
        m_scl = 1'b1; wait_q(2*Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        b = bus_sda; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_q.push_back({31'd0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        sb_check(tag, {31'd0, a});
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp, input logic nack);
        logic [7:0] d;
        logic b;
        exp_q.push_back({24'd0, exp});
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        sb_check(tag, {24'd0, d});
        write_bit(nack);
    endtask

    initial begin
        int base_int;
        int base_low;
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = 6'd0; wb_wdata = 32'd0; wb_sel = 4'd0;
        wait_q(3);
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        chk("rst_sda", {31'd0, s_sda}, 32'd1);
        chk("rst_int", {31'd0, dut_int}, 32'd0);
        chk("scl_out", {31'd0, s_scl}, 32'd1);
        chk("stall", {31'd0, wb_stall}, 32'd0);
        rst = 1'b0;
        wait_q(2);
        wb_read("rst_ctrl", 6'h00, 32'h0000_0050);
        wb_read("rst_ptr", 6'h01, 32'h0000_0000);

        // Write path: pointer 0x10, two data bytes
        wb_write(6'h24, 32'h0102_0304, 4'hF);
        wb_write(6'h28, 32'h5555_5555, 4'hF);
        i2c_start();
        write_byte("t1_addr_ack", 8'hA0, 1'b0);
        write_byte("t1_ptr_ack", 8'h10, 1'b0);
        wb_read("t1_busy", 6'h00, 32'h8000_0050);
        write_byte("t1_d0_ack", 8'hA5, 1'b0);
        write_byte("t1_d1_ack", 8'h5A, 1'b0);
        i2c_stop();
        wb_read("t1_word4", 6'h24, 32'hA55A_0304);
        wb_read("t1_ptr", 6'h01, 32'h0000_0012);
        chk("t1_int", int_cnt, 1);
        wb_read("t1_ctrl", 6'h00, 32'h4000_0050);
        wb_write(6'h00, 32'h0000_0050, 4'hF);
        wb_read("t1_wrclr", 6'h00, 32'h0000_0050);

        // Read path with repeated start
        wb_write(6'h20, 32'h1122_3344, 4'hF);
        i2c_start();
        write_byte("t2_addr_ack", 8'hA0, 1'b0);
        write_byte("t2_ptr_ack", 8'h01, 1'b0);
        i2c_rstart();
        write_byte("t2_raddr_ack", 8'hA1, 1'b0);
        read_byte("t2_rd0", 8'h22, 1'b0);
        read_byte("t2_rd1", 8'h33, 1'b0);
        read_byte("t2_rd2", 8'h44, 1'b1);
        chk("t2_sda_rel", {31'd0, s_sda}, 32'd1);
        i2c_stop();
        wb_read("t2_ptr", 6'h01, 32'h0000_0004);
        chk("t2_int", int_cnt, 1);

        // Address mismatch
        base_low = sda_low_cnt;
        i2c_start();
        write_byte("t3_nack", 8'hA2, 1'b1);
        wb_read("t3_busy", 6'h00, 32'h0000_0050);
        i2c_stop();
        chk("t3_sda_low", sda_low_cnt - base_low, 0);

        // Pointer wrap
        wb_write(6'h3F, 32'hCAFE_BABE, 4'hF);
        i2c_start();
        write_byte("t4_addr", 8'hA0, 1'b0);
        write_byte("t4_ptr", 8'h7F, 1'b0);
        write_byte("t4_d0", 8'hDE, 1'b0);
        write_byte("t4_d1", 8'hAD, 1'b0);
        i2c_stop();
        wb_read("t4_word31", 6'h3F, 32'hCAFE_BADE);
        wb_read("t4_word0", 6'h20, 32'hAD22_3344);
        wb_read("t4_ptr", 6'h01, 32'h0000_0001);
        chk("t4_int", int_cnt, 2);

        // Wishbone write burst spanning completion of an I2C byte to word 4
        i2c_start();
        write_byte("t5_addr", 8'hA0, 1'b0);
        write_byte("t5_ptr", 8'h10, 1'b0);
        fork
            write_byte("t5_d0", 8'hC3, 1'b0);
            begin
                repeat (600) @(negedge clk);
                wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
                wb_addr = 6'h24; wb_wdata = 32'h9988_7766; wb_sel = 4'hF;
                repeat (40) @(negedge clk);
                wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            end
        join
        i2c_stop();
        wb_read("t5_word4", 6'h24, 32'hC388_7766);
        chk("t5_int", int_cnt, 3);

        // Locked memory refuses data
        wb_write(6'h00, 32'h0000_0150, 4'hF);
        base_int = int_cnt;
        i2c_start();
        write_byte("t6_addr", 8'hA0, 1'b0);
        write_byte("t6_ptr", 8'h30, 1'b0);
        write_byte("t6_lock_nack", 8'h77, 1'b1);
        i2c_stop();
        wb_read("t6_ctrl", 6'h00, 32'h0000_0150);
        wb_read("t6_ptr", 6'h01, 32'h0000_0030);
        chk("t6_int", int_cnt - base_int, 0);

        // Reset during bit 5 of a data byte
        wb_write(6'h00, 32'h0000_0050, 4'hF);
        i2c_start();
        write_byte("t7_addr", 8'hA0, 1'b0);
        write_byte("t7_ptr", 8'h20, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        rst = 1'b1;
        #1;
        chk("t7_rst_sda", {31'd0, s_sda}, 32'd1);
        wait_q(3);
        rst = 1'b0;
        wait_q(Q);
        m_sda = 1'b1; wait_q(2*Q);
        wb_read("t7_word8", 6'h28, 32'h5555_5555);
        wb_read("t7_ptr_rst", 6'h01, 32'h0000_0000);
        i2c_start();
        write_byte("t7_addr2", 8'hA0, 1'b0);
        i2c_stop();
        wb_read("t7_ctrl", 6'h00, 32'h0000_0050);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
